// File: rtl/mem_resp_pkg.sv
// Shared types and sizing helpers for the memory-side line responder.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package mem_resp_pkg;

    // Responder control states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_READ_BURST,
        ST_WRITE_BURST,
        ST_RESP
    } state_t;

    // Bit width needed to hold values 0..n-1, never less than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Byte-address bit where the line index starts (word offset + byte offset).
    function automatic int line_off(input int words_per_line);
        return $clog2(words_per_line) + 2;
    endfunction

    // Beat counter width for a burst of words_per_line beats.
    function automatic int beat_w(input int words_per_line);
        return clog2_min1(words_per_line);
    endfunction

endpackage

// File: rtl/mem_word_array.sv
// Single-port word RAM with synchronous write and registered read data.
// Latency: read data appears the cycle after a read-enabled edge; writes commit at the edge.
// Backpressure: none; every enabled access completes in one cycle.
//
// Ports: clk/rst_n (rst_n only clears the read register, never the contents),
//        en/we select read or write, addr word address, wdata write word, rdata read word.
module mem_word_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int AW     = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register holds its value between reads so the fill beat stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_line_responder.sv
// Memory-side responder serving cache line fills and writebacks from a local word array.
// Latency: first burst beat LATENCY cycles after request accept; done one cycle after last beat.
// Backpressure: req_ready only in IDLE; writeback beats paced by wr_valid; fill beats never stall.
//
// Ports: clk, rst_n (async active-low); req_valid/req_ready/req_write/req_addr request;
//        wr_valid/wr_data/wr_ready writeback beats; rd_valid/rd_data/rd_last fill beats;
//        done one-cycle completion pulse; busy transaction in progress.
module mem_line_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int WORDS_PER_LINE  = 4,
    parameter int MEM_DEPTH_WORDS = 1024,
    parameter int LATENCY         = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              done,
    output logic              busy
);

    localparam int OFF       = line_off(WORDS_PER_LINE);
    localparam int BEAT_W    = beat_w(WORDS_PER_LINE);
    localparam int NUM_LINES = MEM_DEPTH_WORDS / WORDS_PER_LINE;
    localparam int LINE_W    = clog2_min1(NUM_LINES);
    localparam int AW        = LINE_W + BEAT_W;
    localparam int UPPER_W   = ADDR_W - OFF;
    localparam int LAT_W     = clog2_min1(LATENCY);

    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(WORDS_PER_LINE - 1);

    state_t              state;
    logic [LINE_W-1:0]   line_q;
    logic                write_q;
    logic [BEAT_W-1:0]   beat;
    logic [LAT_W-1:0]    lat_cnt;

    logic [BEAT_W-1:0]   beat_inc;
    logic                rd_en;
    logic                wr_en;
    logic [AW-1:0]       arr_addr;

    // Word/byte offset bits of the request address carry no meaning here.
    logic                unused_addr_bits;
    assign unused_addr_bits = ^req_addr[OFF-1:0];

    assign beat_inc = beat + BEAT_W'(1);

    // The array read register adds a cycle, so each fill word is fetched one cycle
    // ahead: beat 0 on the last WAIT cycle, beat b+1 while beat b is on the bus.
    assign rd_en = ((state == ST_WAIT) && (lat_cnt == '0) && !write_q) ||
                   ((state == ST_READ_BURST) && (beat != BEAT_LAST));
    assign wr_en = (state == ST_WRITE_BURST) && wr_valid;

    always_comb begin
        arr_addr = {line_q, beat};
        if (state == ST_WAIT) begin
            arr_addr = {line_q, {BEAT_W{1'b0}}};
        end else if (state == ST_READ_BURST) begin
            arr_addr = {line_q, beat_inc};
        end
    end

    mem_word_array #(
        .DATA_W (DATA_W),
        .DEPTH  (MEM_DEPTH_WORDS),
        .AW     (AW)
    ) u_array (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (rd_en || wr_en),
        .we     (wr_en),
        .addr   (arr_addr),
        .wdata  (wr_data),
        .rdata  (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            line_q    <= '0;
            write_q   <= 1'b0;
            beat      <= '0;
            lat_cnt   <= '0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            wr_ready  <= 1'b0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        // Upper address bits alias onto the array.
                        line_q    <= LINE_W'(req_addr[ADDR_W-1:OFF] % UPPER_W'(NUM_LINES));
                        write_q   <= req_write;
                        lat_cnt   <= LAT_W'(LATENCY - 1);
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (lat_cnt == '0) begin
                        beat <= '0;
                        if (write_q) begin
                            wr_ready <= 1'b1;
                            state    <= ST_WRITE_BURST;
                        end else begin
                            rd_valid <= 1'b1;
                            rd_last  <= 1'b0;
                            state    <= ST_READ_BURST;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end

                ST_READ_BURST: begin
                    if (beat == BEAT_LAST) begin
                        rd_valid <= 1'b0;
                        rd_last  <= 1'b0;
                        done     <= 1'b1;
                        beat     <= '0;
                        state    <= ST_RESP;
                    end else begin
                        beat    <= beat_inc;
                        rd_last <= (beat_inc == BEAT_LAST);
                    end
                end

                ST_WRITE_BURST: begin
                    if (wr_valid) begin
                        if (beat == BEAT_LAST) begin
                            wr_ready <= 1'b0;
                            done     <= 1'b1;
                            beat     <= '0;
                            state    <= ST_RESP;
                        end else begin
                            beat <= beat_inc;
                        end
                    end
                end

                ST_RESP: begin
                    done      <= 1'b0;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end

                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    wr_ready  <= 1'b0;
                    rd_valid  <= 1'b0;
                    rd_last   <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_line_responder.sv
// Bench for mem_line_responder: directed and random fills/writebacks against a word-array model.
// Latency: drives and samples on the falling clock edge, one transaction at a time.
// Backpressure: bench paces writeback beats with optional gaps and holds req_valid on request.
module tb_mem_line_responder;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int WPL     = 4;
    localparam int DEPTH   = 1024;
    localparam int LATENCY = 3;
    localparam int OFF     = 4;
    localparam int NLINES  = DEPTH / WPL;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;
    logic              done;
    logic              busy;

    int checks = 0;
    int errors = 0;

    // Reference memory: contents plus a flag saying whether the bench has defined the word.
    logic [DATA_W-1:0] model_mem [DEPTH];
    bit                model_vld [DEPTH];

    always #5 clk = ~clk;

    mem_line_responder #(
        .ADDR_W          (ADDR_W),
        .DATA_W          (DATA_W),
        .WORDS_PER_LINE  (WPL),
        .MEM_DEPTH_WORDS (DEPTH),
        .LATENCY         (LATENCY)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .done      (done),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int line_of(input logic [31:0] a);
        return int'((a >> OFF) % NLINES);
    endfunction

    // One complete transaction, entered and left at a falling edge with the DUT idle.
    task automatic do_txn(input bit wr, input logic [31:0] addr,
                          input logic [31:0] wd [WPL], input int gaps [WPL], input bit hold);
        int base;
        int b;
        int g;
        base = line_of(addr) * WPL;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        chk("accept_ready", req_ready, 1);
        @(negedge clk);
        if (!hold) begin
            req_valid = 1'b0;
            req_addr  = $urandom;
            req_write = 1'($urandom_range(0, 1));
        end
        // Latency window; stray writeback beats here must be ignored.
        for (int c = 0; c < LATENCY; c++) begin
            chk("wait_busy", busy, 1);
            chk("wait_req_ready", req_ready, 0);
            chk("wait_wr_ready", wr_ready, 0);
            chk("wait_rd_valid", rd_valid, 0);
            chk("wait_done", done, 0);
            wr_valid = 1'($urandom_range(0, 1));
            wr_data  = $urandom;
            @(negedge clk);
        end
        if (!wr) begin
            for (int k = 0; k < WPL; k++) begin
                chk("fill_rd_valid", rd_valid, 1);
                chk("fill_rd_last", rd_last, (k == WPL - 1));
                if (model_vld[base + k]) chk("fill_rd_data", rd_data, model_mem[base + k]);
                chk("fill_wr_ready", wr_ready, 0);
                chk("fill_done", done, 0);
                wr_valid = 1'($urandom_range(0, 1));
                wr_data  = $urandom;
                @(negedge clk);
            end
        end else begin
            b = 0;
            g = 0;
            while (b < WPL) begin
                chk("wb_wr_ready", wr_ready, 1);
                chk("wb_done", done, 0);
                chk("wb_rd_valid", rd_valid, 0);
                chk("wb_busy", busy, 1);
                if (g < gaps[b]) begin
                    wr_valid = 1'b0;
                    wr_data  = $urandom;
                    g++;
                end else begin
                    wr_valid = 1'b1;
                    wr_data  = wd[b];
                    model_mem[base + b] = wd[b];
                    model_vld[base + b] = 1'b1;
                    b++;
                    g = 0;
                end
                @(negedge clk);
            end
        end
        wr_valid = 1'b0;
        chk("resp_done", done, 1);
        chk("resp_req_ready", req_ready, 0);
        chk("resp_busy", busy, 1);
        chk("resp_rd_valid", rd_valid, 0);
        chk("resp_wr_ready", wr_ready, 0);
        @(negedge clk);
        chk("idle_done", done, 0);
        chk("idle_req_ready", req_ready, 1);
        chk("idle_busy", busy, 0);
    endtask

    logic [31:0] wd [WPL];
    int          gp [WPL];
    int          nogap [WPL];
    logic [31:0] addr;

    initial begin
        nogap = '{default: 0};
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        repeat (2) @(negedge clk);

        chk("rst_req_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_last", rd_last, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_data", rd_data, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Writeback then fill of the same line through a different word offset.
        wd = '{32'h11, 32'h22, 32'h33, 32'h44};
        do_txn(1'b1, 32'h40, wd, nogap, 1'b0);
        do_txn(1'b0, 32'h4C, wd, nogap, 1'b0);

        // Reset in the middle of a fill burst.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h40;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (LATENCY + 1) @(negedge clk);
        chk("midrst_rd_valid_before", rd_valid, 1);
        chk("midrst_rd_data_before", rd_data, 32'h22);
        rst_n = 1'b0;
        #1;
        chk("midrst_rd_valid", rd_valid, 0);
        chk("midrst_done", done, 0);
        chk("midrst_req_ready", req_ready, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_rd_data", rd_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_txn(1'b0, 32'h48, wd, nogap, 1'b0);

        // Writeback with a two-cycle pause inside the burst, then read back.
        wd = '{32'h55, 32'h66, 32'h77, 32'h88};
        gp = '{0, 0, 2, 0};
        do_txn(1'b1, 32'h200, wd, gp, 1'b0);
        do_txn(1'b0, 32'h204, wd, nogap, 1'b0);

        // req_valid held across a whole transaction: next accept only once idle again.
        do_txn(1'b0, 32'h40, wd, nogap, 1'b1);
        do_txn(1'b0, 32'h40, wd, nogap, 1'b0);

        // Upper address bits alias onto the same line.
        wd = '{32'hA1, 32'hB2, 32'hC3, 32'hD4};
        do_txn(1'b1, 32'h1040, wd, nogap, 1'b0);
        do_txn(1'b0, 32'h40, wd, nogap, 1'b0);

        // Random mix over a few lines with random aliasing upper bits.
        for (int i = 0; i < 30; i++) begin
            addr = ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 7)) << 4)
                   | 32'($urandom_range(0, 15));
            for (int k = 0; k < WPL; k++) begin
                wd[k] = $urandom;
                gp[k] = int'($urandom_range(0, 2));
            end
            do_txn(1'($urandom_range(0, 1)), addr, wd, gp, 1'($urandom_range(0, 1)));
        end
        req_valid = 1'b0;
        @(negedge clk);
        chk("final_idle_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
